// File: rtl/vx_stream_arb.sv
`default_nettype none
// ============================================================================
// Module   : vx_stream_arb
// Purpose  : N-to-1 per-lane stream merger with round-robin arbitration and a
//            selectable output stage (0 = combinational, 1 = pipe register,
//            2 = two-entry skid buffer with registered ready).
// Ports    : clk, reset (async, active-high)
//            valid_in/data_in/ready_in : NUM_REQS x LANES requester streams,
//                                        flat index of requester k, lane j
//                                        is k*LANES + j (data scaled by DATAW)
//            valid_out/data_out/ready_out : one merged stream per lane
//            sel_out : requester index that sourced each output beat
// Revision : 1.0 - initial release
// ============================================================================
module vx_stream_arb #(
    parameter int NUM_REQS     = 1,
    parameter int LANES        = 1,
    parameter int DATAW        = 1,
    parameter int BUFFERED     = 0,
    parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQS*LANES-1:0]       valid_in,
    input  logic [NUM_REQS*LANES*DATAW-1:0] data_in,
    output logic [NUM_REQS*LANES-1:0]       ready_in,
    output logic [LANES-1:0]                valid_out,
    output logic [LANES*DATAW-1:0]          data_out,
    output logic [LANES*LOG_NUM_REQS-1:0]   sel_out,
    input  logic [LANES-1:0]                ready_out
);

    // (base + offs) mod NUM_REQS; NUM_REQS need not be a power of two.
    function automatic logic [LOG_NUM_REQS-1:0] wrap_add(
        input logic [LOG_NUM_REQS-1:0] base,
        input int                      offs
    );
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQS) begin
            sum = sum - NUM_REQS;
        end
        return LOG_NUM_REQS'(sum);
    endfunction

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        if (NUM_REQS == 1) begin : g_pass
            // Single requester: pure wiring, no state.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ reset;

            assign valid_out[j]                             = valid_in[j];
            assign data_out[j*DATAW +: DATAW]               = data_in[j*DATAW +: DATAW];
            assign sel_out[j*LOG_NUM_REQS +: LOG_NUM_REQS]  = '0;
            assign ready_in[j]                              = ready_out[j];
        end else begin : g_arb
            logic [LOG_NUM_REQS-1:0] r_ptr;
            logic [LOG_NUM_REQS-1:0] r_lock_idx;
            logic                    r_lock_vld;
            logic [LOG_NUM_REQS-1:0] w_rr_idx;
            logic [LOG_NUM_REQS-1:0] w_winner;
            logic                    w_arb_valid;
            logic [DATAW-1:0]        w_arb_data;
            logic                    w_stage_ready;
            logic                    w_arb_fire;

            // Scan from the farthest offset back to ptr so the closest valid
            // requester (in round-robin order) is the last one assigned.
            // With no valid requester the winner defaults to ptr.
            always_comb begin
                w_rr_idx = r_ptr;
                for (int i = NUM_REQS - 1; i >= 0; i--) begin
                    if (valid_in[int'(wrap_add(r_ptr, i))*LANES + j]) begin
                        w_rr_idx = wrap_add(r_ptr, i);
                    end
                end
            end

            // A stalled beat keeps its grant so the output cannot change
            // under a waiting consumer.
            assign w_winner    = r_lock_vld ? r_lock_idx : w_rr_idx;
            assign w_arb_valid = valid_in[int'(w_winner)*LANES + j];
            assign w_arb_data  = data_in[(int'(w_winner)*LANES + j)*DATAW +: DATAW];
            assign w_arb_fire  = w_arb_valid && w_stage_ready;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ptr      <= '0;
                    r_lock_vld <= 1'b0;
                    r_lock_idx <= '0;
                end else begin
                    if (w_arb_fire) begin
                        r_ptr      <= wrap_add(w_winner, 1);
                        r_lock_vld <= 1'b0;
                    end else if (w_arb_valid) begin
                        // valid without fire means the stage below stalled
                        r_lock_vld <= 1'b1;
                        r_lock_idx <= w_winner;
                    end
                end
            end

            // Only the current winner may see ready; harmless if its valid is low.
            for (genvar k = 0; k < NUM_REQS; k++) begin : g_rdy
                assign ready_in[k*LANES + j] = (w_winner == LOG_NUM_REQS'(k)) && w_stage_ready;
            end

            if (BUFFERED == 0) begin : g_comb
                assign w_stage_ready                            = ready_out[j];
                assign valid_out[j]                             = w_arb_valid;
                assign data_out[j*DATAW +: DATAW]               = w_arb_data;
                assign sel_out[j*LOG_NUM_REQS +: LOG_NUM_REQS]  = w_winner;
            end else if (BUFFERED == 1) begin : g_pipe
                logic                    r_full;
                logic [DATAW-1:0]        r_data;
                logic [LOG_NUM_REQS-1:0] r_sel;

                // Full buffer can refill in the same cycle it drains.
                assign w_stage_ready = !reset && (!r_full || ready_out[j]);

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_full <= 1'b0;
                        r_data <= '0;
                        r_sel  <= '0;
                    end else if (!r_full || ready_out[j]) begin
                        r_full <= w_arb_fire;
                        if (w_arb_fire) begin
                            r_data <= w_arb_data;
                            r_sel  <= w_winner;
                        end
                    end
                end

                assign valid_out[j]                             = r_full;
                assign data_out[j*DATAW +: DATAW]               = r_data;
                assign sel_out[j*LOG_NUM_REQS +: LOG_NUM_REQS]  = r_sel;
            end else begin : g_skid
                logic                    r_out_vld;
                logic [DATAW-1:0]        r_out_data;
                logic [LOG_NUM_REQS-1:0] r_out_sel;
                logic                    r_skid_vld;
                logic [DATAW-1:0]        r_skid_data;
                logic [LOG_NUM_REQS-1:0] r_skid_sel;

                // Ready comes from the skid flop only: no ready_out -> ready_in path.
                assign w_stage_ready = !reset && !r_skid_vld;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_out_vld   <= 1'b0;
                        r_out_data  <= '0;
                        r_out_sel   <= '0;
                        r_skid_vld  <= 1'b0;
                        r_skid_data <= '0;
                        r_skid_sel  <= '0;
                    end else if (!r_out_vld || ready_out[j]) begin
                        // Output slot free or draining: the older skid beat
                        // moves up first to keep acceptance order.
                        if (r_skid_vld) begin
                            r_out_vld  <= 1'b1;
                            r_out_data <= r_skid_data;
                            r_out_sel  <= r_skid_sel;
                            r_skid_vld <= 1'b0;
                        end else begin
                            r_out_vld <= w_arb_fire;
                            if (w_arb_fire) begin
                                r_out_data <= w_arb_data;
                                r_out_sel  <= w_winner;
                            end
                        end
                    end else if (w_arb_fire) begin
                        // Output stalled: park the beat accepted this cycle.
                        r_skid_vld  <= 1'b1;
                        r_skid_data <= w_arb_data;
                        r_skid_sel  <= w_winner;
                    end
                end

                assign valid_out[j]                             = r_out_vld;
                assign data_out[j*DATAW +: DATAW]               = r_out_data;
                assign sel_out[j*LOG_NUM_REQS +: LOG_NUM_REQS]  = r_out_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vx_stream_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_stream_arb
// Purpose  : Directed self-checking bench for vx_stream_arb covering the
//            combinational, pipe and skid output modes plus the 1-requester
//            passthrough.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vx_stream_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    int checks   = 0;
    int failures = 0;

    // A: 4 requesters, 2 lanes, combinational output
    logic [7:0]  a_valid, a_ready_in;
    logic [63:0] a_data;
    logic [1:0]  a_valid_out, a_ready_out;
    logic [15:0] a_data_out;
    logic [3:0]  a_sel_out;

    // B: 3 requesters, pipe register
    logic [2:0]  b_valid, b_ready_in;
    logic [23:0] b_data;
    logic        b_valid_out, b_ready_out;
    logic [7:0]  b_data_out;
    logic [1:0]  b_sel_out;

    // C: 2 requesters, skid buffer
    logic [1:0]  c_valid, c_ready_in;
    logic [15:0] c_data;
    logic        c_valid_out, c_ready_out;
    logic [7:0]  c_data_out;
    logic [0:0]  c_sel_out;

    // D: single requester passthrough, 2 lanes
    logic [1:0]  d_valid, d_ready_in, d_valid_out, d_ready_out, d_sel_out;
    logic [7:0]  d_data, d_data_out;

    vx_stream_arb #(.NUM_REQS(4), .LANES(2), .DATAW(8), .BUFFERED(0)) u_a (
        .clk(clk), .reset(reset), .valid_in(a_valid), .data_in(a_data),
        .ready_in(a_ready_in), .valid_out(a_valid_out), .data_out(a_data_out),
        .sel_out(a_sel_out), .ready_out(a_ready_out));

    vx_stream_arb #(.NUM_REQS(3), .LANES(1), .DATAW(8), .BUFFERED(1)) u_b (
        .clk(clk), .reset(reset), .valid_in(b_valid), .data_in(b_data),
        .ready_in(b_ready_in), .valid_out(b_valid_out), .data_out(b_data_out),
        .sel_out(b_sel_out), .ready_out(b_ready_out));

    vx_stream_arb #(.NUM_REQS(2), .LANES(1), .DATAW(8), .BUFFERED(2)) u_c (
        .clk(clk), .reset(reset), .valid_in(c_valid), .data_in(c_data),
        .ready_in(c_ready_in), .valid_out(c_valid_out), .data_out(c_data_out),
        .sel_out(c_sel_out), .ready_out(c_ready_out));

    vx_stream_arb #(.NUM_REQS(1), .LANES(2), .DATAW(4), .BUFFERED(0)) u_d (
        .clk(clk), .reset(reset), .valid_in(d_valid), .data_in(d_data),
        .ready_in(d_ready_in), .valid_out(d_valid_out), .data_out(d_data_out),
        .sel_out(d_sel_out), .ready_out(d_ready_out));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int k, input int j, input logic v, input logic [7:0] d);
        a_valid[k*2 + j]          = v;
        a_data[(k*2 + j)*8 +: 8]  = d;
    endtask

    int          cnt [2];
    int          got [2];
    logic        acc [2];
    logic        tog;
    logic [1:0]  rin;
    int          s;

    initial begin
        reset = 1'b1;
        a_valid = '0; a_data = '0; a_ready_out = '0;
        b_valid = '0; b_data = '0; b_ready_out = '0;
        c_valid = '0; c_data = '0; c_ready_out = '0;
        d_valid = '0; d_data = '0; d_ready_out = '0;
        #12;
        // ---------------- reset state ----------------
        check("rst_a_valid_out", 32'(a_valid_out), 0);
        check("rst_b_valid_out", 32'(b_valid_out), 0);
        check("rst_b_ready_in",  32'(b_ready_in), 0);
        check("rst_b_data_out",  32'(b_data_out), 0);
        check("rst_c_valid_out", 32'(c_valid_out), 0);
        check("rst_c_ready_in",  32'(c_ready_in), 0);
        tick;
        reset = 1'b0;

        // ---------------- passthrough ----------------
        d_valid = 2'b10; d_data = 8'h5A; d_ready_out = 2'b01;
        #1;
        check("pass_valid", 32'(d_valid_out), 'b10);
        check("pass_data",  32'(d_data_out), 'h5A);
        check("pass_sel",   32'(d_sel_out), 0);
        check("pass_ready", 32'(d_ready_in), 'b01);
        tick;

        // ---------------- fairness ----------------
        for (int k = 0; k < 4; k++) set_a(k, 0, 1'b1, 8'(8'h10 + k));
        a_ready_out = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("fair_sel",   32'(a_sel_out[1:0]), i % 4);
            check("fair_data",  32'(a_data_out[7:0]), 'h10 + i % 4);
            check("fair_ready", 32'(a_ready_in), 'b10 | (1 << ((i % 4) * 2)));
            tick;
        end

        // ---------------- skip and wrap (ptr = 2) ----------------
        for (int k = 0; k < 4; k++) set_a(k, 0, 1'b0, 8'h00);
        set_a(1, 0, 1'b1, 8'h41);
        set_a(3, 0, 1'b1, 8'h43);
        #1; check("wrap_sel0", 32'(a_sel_out[1:0]), 3); check("wrap_dat0", 32'(a_data_out[7:0]), 'h43);
        tick;
        #1; check("wrap_sel1", 32'(a_sel_out[1:0]), 1); check("wrap_dat1", 32'(a_data_out[7:0]), 'h41);
        tick;
        #1; check("wrap_sel2", 32'(a_sel_out[1:0]), 3);
        tick;
        set_a(1, 0, 1'b0, 8'h00);
        set_a(3, 0, 1'b0, 8'h00);

        // ---------------- stall lock, ptr = 0 ----------------
        set_a(0, 0, 1'b1, 8'hA5);
        a_ready_out[0] = 1'b0;
        #1;
        check("lock_valid", 32'(a_valid_out[0]), 1);
        check("lock_sel_c1", 32'(a_sel_out[1:0]), 0);
        tick;
        set_a(2, 0, 1'b1, 8'hC3);
        for (int c = 0; c < 2; c++) begin
            #1;
            check("lock_data", 32'(a_data_out[7:0]), 'hA5);
            check("lock_sel",  32'(a_sel_out[1:0]), 0);
            check("lock_rdy2", 32'(a_ready_in[4]), 0);
            tick;
        end
        a_ready_out[0] = 1'b1;
        #1;
        check("lock_rel_data", 32'(a_data_out[7:0]), 'hA5);
        check("lock_rel_rdy0", 32'(a_ready_in[0]), 1);
        tick;
        set_a(0, 0, 1'b0, 8'h00);
        #1;
        check("lock_next_sel",  32'(a_sel_out[1:0]), 2);
        check("lock_next_data", 32'(a_data_out[7:0]), 'hC3);
        tick;
        set_a(2, 0, 1'b0, 8'h00);

        // ---------------- stall lock against a higher-priority arrival (ptr = 3) ----------------
        set_a(0, 0, 1'b1, 8'h5A);
        a_ready_out[0] = 1'b0;
        #1; check("lock2_sel0", 32'(a_sel_out[1:0]), 0);
        tick;
        set_a(3, 0, 1'b1, 8'h3C);
        #1;
        check("lock2_hold_sel",  32'(a_sel_out[1:0]), 0);
        check("lock2_hold_data", 32'(a_data_out[7:0]), 'h5A);
        check("lock2_rdy3",      32'(a_ready_in[6]), 0);
        tick;
        a_ready_out[0] = 1'b1;
        #1; check("lock2_rel_sel", 32'(a_sel_out[1:0]), 0);
        tick;
        set_a(0, 0, 1'b0, 8'h00);
        #1;
        check("lock2_next_sel",  32'(a_sel_out[1:0]), 3);
        check("lock2_next_data", 32'(a_data_out[7:0]), 'h3C);
        tick;
        set_a(3, 0, 1'b0, 8'h00);

        // ---------------- lane independence (lane0 ptr = 0, lane1 ptr = 0) ----------------
        set_a(1, 0, 1'b1, 8'h77);
        for (int k = 0; k < 4; k++) set_a(k, 1, 1'b1, 8'(8'h20 + k));
        a_ready_out = 2'b10;
        #1;
        check("lane0_sel_start", 32'(a_sel_out[1:0]), 1);
        check("lane1_sel_start", 32'(a_sel_out[3:2]), 0);
        tick;
        set_a(0, 0, 1'b1, 8'h70);
        for (int i = 1; i < 6; i++) begin
            #1;
            check("lane1_sel",   32'(a_sel_out[3:2]), i % 4);
            check("lane1_data",  32'(a_data_out[15:8]), 'h20 + i % 4);
            check("lane0_valid", 32'(a_valid_out[0]), 1);
            check("lane0_sel",   32'(a_sel_out[1:0]), 1);
            check("lane0_data",  32'(a_data_out[7:0]), 'h77);
            tick;
        end
        a_ready_out[0] = 1'b1;
        #1; check("lane0_rel_sel", 32'(a_sel_out[1:0]), 1);
        tick;
        set_a(1, 0, 1'b0, 8'h00);
        #1;
        check("lane0_after_sel",  32'(a_sel_out[1:0]), 0);
        check("lane0_after_data", 32'(a_data_out[7:0]), 'h70);
        tick;
        a_valid = '0;

        // ---------------- skid buffer streaming ----------------
        cnt[0] = 0; cnt[1] = 0; got[0] = 0; got[1] = 0;
        tog = 1'b1;
        for (int cyc = 0; cyc < 80 && (got[0] < 8 || got[1] < 8); cyc++) begin
            for (int k = 0; k < 2; k++) begin
                c_valid[k]         = (cnt[k] < 8);
                c_data[k*8 +: 8]   = 8'(k*16 + cnt[k]);
            end
            c_ready_out = tog;
            #1;
            rin = c_ready_in;
            c_ready_out = ~tog;
            #1;
            check("skid_ready_indep", 32'(c_ready_in), 32'(rin));
            c_ready_out = tog;
            #1;
            if (c_valid_out && c_ready_out) begin
                s = int'(c_sel_out);
                check("skid_sel_tag", 32'(c_data_out[7:4]), 32'(s));
                check("skid_order",   32'(c_data_out[3:0]), 32'(got[s & 1]));
                got[s & 1]++;
            end
            for (int k = 0; k < 2; k++) acc[k] = c_valid[k] && c_ready_in[k];
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) if (acc[k]) cnt[k]++;
            tog = ~tog;
        end
        check("skid_count0", 32'(got[0]), 8);
        check("skid_count1", 32'(got[1]), 8);
        c_valid = '0;
        c_ready_out = 1'b1;
        tick;
        #1; check("skid_no_dup", 32'(c_valid_out), 0);

        // ---------------- pipe register: throughput and non-pow2 wrap ----------------
        b_valid = 3'b111; b_data = 24'h323130; b_ready_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("pipe_ready", 32'(b_ready_in), 1 << (i % 3));
            if (i == 0) begin
                check("pipe_empty", 32'(b_valid_out), 0);
            end else begin
                check("pipe_valid", 32'(b_valid_out), 1);
                check("pipe_sel",   32'(b_sel_out), (i - 1) % 3);
                check("pipe_data",  32'(b_data_out), 'h30 + (i - 1) % 3);
            end
            tick;
        end
        b_ready_out = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("pipe_hold_valid", 32'(b_valid_out), 1);
            check("pipe_hold_sel",   32'(b_sel_out), 1);
            check("pipe_hold_data",  32'(b_data_out), 'h31);
            check("pipe_hold_ready", 32'(b_ready_in), 0);
            tick;
        end

        // ---------------- async reset mid-cycle ----------------
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid_out", 32'(b_valid_out), 0);
        check("arst_data_out",  32'(b_data_out), 0);
        check("arst_sel_out",   32'(b_sel_out), 0);
        check("arst_ready_in",  32'(b_ready_in), 0);
        tick;
        reset = 1'b0;
        b_ready_out = 1'b1;
        #1;
        check("arst_first_ready", 32'(b_ready_in), 'b001);
        tick;
        #1;
        check("arst_first_sel",  32'(b_sel_out), 0);
        check("arst_first_data", 32'(b_data_out), 'h30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
